irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 16, number of interrupt request lines, legal range 1..16.
REQ-002 clk_i  input  1  system clock, all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset: low clears all state immediately, independent of clk_i.
REQ-004 irq_req_i  input  N_IRQ  level interrupt requests, synchronous to clk_i, bit k = line k.
REQ-005 mie_i  input  32  CSR mie value; bit 16+k enables line k, other bits ignored.
REQ-006 int_ack_i  input  1  core accepted the trap at an instruction boundary (same cycle it drives the CSR trap operation).
REQ-007 mret_i  input  1  core retires mret, one-cycle pulse.
REQ-008 int_o  output  1  trap request to core, registered.
REQ-009 mcause_o  output  32  cause value for the CSR mcause trap write, registered.
REQ-010 irq_ret_o  output  N_IRQ  one-hot end-of-service pulse back to the serviced device, registered.
REQ-011 busy_o  output  1  high in any state except IDLE, registered.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, PENDING, SERVICE, RET.
REQ-013 Eligible set = irq_req_i[k] & mie_i[16+k]; the winner is the lowest eligible index k (fixed priority, line 0 highest).
REQ-014 IDLE: if eligible set is non-empty at edge n, go to PENDING; int_o=1 and mcause_o=0x8000_0000|(16+k) visible after edge n (1-cycle latency from request to int_o).
REQ-015 The winner index SHALL be latched on IDLE->PENDING and held unchanged through PENDING, SERVICE and RET.
REQ-016 PENDING: int_o held 1; deassertion of irq_req_i or clearing of mie_i for the latched line SHALL NOT cancel the request.
REQ-017 PENDING with int_ack_i=1: go to SERVICE; int_o=0 after that edge.
REQ-018 SERVICE: int_o=0; new requests, including higher-priority ones, SHALL NOT preempt (no nesting); they remain visible on irq_req_i and are evaluated on return to IDLE.
REQ-019 SERVICE with mret_i=1: go to RET; irq_ret_o[latched k]=1 for exactly the one cycle spent in RET, all other bits 0.
REQ-020 RET: unconditionally go to IDLE next edge; irq_ret_o returns to 0.
REQ-021 IDLE: eligible set is evaluated on the first edge in IDLE; the minimum gap from irq_ret_o pulse to next int_o is 1 cycle of IDLE.
REQ-022 int_ack_i outside PENDING and mret_i outside SERVICE SHALL be ignored with no state or output change.
REQ-023 int_ack_i and mret_i both high in PENDING: ack taken (go to SERVICE), mret ignored.
REQ-024 mcause_o SHALL update only on IDLE->PENDING and otherwise hold its last value, including in IDLE.
REQ-025 busy_o=1 in PENDING, SERVICE, RET; 0 in IDLE.
REQ-026 Unused irq_req_i bits SHALL not exist (width = N_IRQ); mie_i bits above 16+N_IRQ-1 are ignored.

Reset
REQ-027 rst_i low SHALL force state IDLE, int_o=0, mcause_o=0, irq_ret_o=0, busy_o=0, latched index=0 asynchronously.
REQ-028 Reset asserted in any state mid-operation SHALL abort service with no irq_ret_o pulse; after rst_i rises, first evaluation occurs on the first clk_i edge.

Verification
REQ-029 irq_req_i=0x0004, mie_i=0x0004_0000, edge n -> int_o=1 and mcause_o=0x8000_0012 after edge n; int_ack_i at n+3 -> int_o=0 after n+3.
REQ-030 irq_req_i=0x0006, mie_i=0x0006_0000 -> mcause_o=0x8000_0011 (line 1 wins); after mret_i, irq_ret_o=0x0002 for one cycle, then line 2 served with mcause_o=0x8000_0012.
REQ-031 irq_req_i=0x0001, mie_i=0 -> int_o stays 0 for 10 cycles; set mie_i=0x0001_0000 -> int_o=1 one edge later.
REQ-032 In SERVICE for line 3, assert irq_req_i bit 0 (enabled) -> int_o stays 0 until RET completes; mret_i in PENDING or IDLE -> no irq_ret_o pulse.
REQ-033 rst_i low mid-SERVICE -> int_o, mcause_o, irq_ret_o, busy_o all 0 immediately without clock; no irq_ret_o pulse after release.

Source files
------------

// File: rtl/irq_ctrl.sv
// Fixed-priority, non-nesting interrupt controller: one request is latched,
// handed to the core, serviced, and acknowledged back to the device on mret.
module irq_ctrl #(
  parameter int unsigned N_IRQ = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [31:0]      mie_i,
  input  logic             int_ack_i,
  input  logic             mret_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_ret_o,
  output logic             busy_o
);

  localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVICE = 2'd2,
    RET     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               int_q, int_d;
  logic [31:0]        mcause_q, mcause_d;
  logic [N_IRQ-1:0]   irq_ret_q, irq_ret_d;
  logic               busy_q, busy_d;

  logic [N_IRQ-1:0]   elig_c;
  logic [IDX_W-1:0]   win_c;
  logic               any_c;

  // Only the enable bits for implemented lines matter; the rest are read here
  // so the full CSR can be wired in unchanged.
  logic unused_mie;
  assign unused_mie = &{1'b0, mie_i};

  // Eligible lines and the lowest-index winner (line 0 has highest priority).
  always_comb begin
    elig_c = irq_req_i & mie_i[16 +: N_IRQ];
    any_c  = |elig_c;
    win_c  = '0;
    for (int k = int'(N_IRQ) - 1; k >= 0; k--) begin
      if (elig_c[k]) begin
        win_c = IDX_W'(k);
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mcause_d  = mcause_q;
    int_d     = 1'b0;
    irq_ret_d = '0;

    case (state_q)
      IDLE: begin
        if (any_c) begin
          state_d  = PENDING;
          idx_d    = win_c;
          mcause_d = 32'h8000_0010 + 32'(win_c);
          int_d    = 1'b1;
        end
      end
      PENDING: begin
        if (int_ack_i) begin
          state_d = SERVICE;
        end else begin
          int_d = 1'b1;
        end
      end
      SERVICE: begin
        if (mret_i) begin
          state_d   = RET;
          irq_ret_d = N_IRQ'(1) << idx_q;
        end
      end
      RET: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      int_q     <= 1'b0;
      mcause_q  <= 32'h0;
      irq_ret_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      int_q     <= int_d;
      mcause_q  <= mcause_d;
      irq_ret_q <= irq_ret_d;
      busy_q    <= busy_d;
    end
  end

  assign int_o     = int_q;
  assign mcause_o  = mcause_q;
  assign irq_ret_o = irq_ret_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus random traffic,
// all compared against a transaction-level reference model.
module tb_irq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] irq_req_i;
  logic [31:0] mie_i;
  logic        int_ack_i;
  logic        mret_i;
  logic        int_o;
  logic [31:0] mcause_o;
  logic [15:0] irq_ret_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(.N_IRQ(16)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .irq_req_i (irq_req_i),
    .mie_i     (mie_i),
    .int_ack_i (int_ack_i),
    .mret_i    (mret_i),
    .int_o     (int_o),
    .mcause_o  (mcause_o),
    .irq_ret_o (irq_ret_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: phase of the interrupt handshake plus the latched line.
  // phase 0 = waiting, 1 = offered to core, 2 = handler running, 3 = returning
  int          m_phase;
  int          m_line;
  logic [31:0] m_cause;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_line  = 0;
    m_cause = 32'h0;
  endtask

  // Apply the handshake rules for one rising edge with the given inputs.
  task automatic model_edge(input logic [15:0] req, input logic [31:0] mie,
                            input logic ack, input logic mret);
    logic [15:0] elig;
    logic [15:0] lowest;
    elig = req & mie[31:16];
    case (m_phase)
      0: if (elig != 16'h0) begin
           lowest  = elig & (~elig + 16'd1);
           m_line  = $clog2(lowest);
           m_cause = 32'h8000_0000 | 32'(16 + m_line);
           m_phase = 1;
         end
      1: if (ack) m_phase = 2;
      2: if (mret) m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_model(input string tag);
    logic [15:0] ret_exp;
    ret_exp = (m_phase == 3) ? (16'h1 << m_line) : 16'h0;
    check({tag, ".int"},    32'(int_o),     32'(m_phase == 1));
    check({tag, ".cause"},  mcause_o,       m_cause);
    check({tag, ".ret"},    32'(irq_ret_o), 32'(ret_exp));
    check({tag, ".busy"},   32'(busy_o),    32'(m_phase != 0));
  endtask

  // One clock: drive at the falling edge, sample 1ns after the rising edge.
  task automatic cycle(input string tag, input logic [15:0] req, input logic [31:0] mie,
                       input logic ack, input logic mret);
    irq_req_i = req;
    mie_i     = mie;
    int_ack_i = ack;
    mret_i    = mret;
    @(posedge clk_i);
    model_edge(req, mie, ack, mret);
    #1;
    check_model(tag);
    @(negedge clk_i);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic async_reset(input string tag);
    #1;
    rst_i = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_int"},   32'(int_o),     32'h0);
    check({tag, ".rst_cause"}, mcause_o,       32'h0);
    check({tag, ".rst_ret"},   32'(irq_ret_o), 32'h0);
    check({tag, ".rst_busy"},  32'(busy_o),    32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i     = 1'b0;
    irq_req_i = '0;
    mie_i     = '0;
    int_ack_i = 1'b0;
    mret_i    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check("reset.int",   32'(int_o),     32'h0);
    check("reset.cause", mcause_o,       32'h0);
    check("reset.ret",   32'(irq_ret_o), 32'h0);
    check("reset.busy",  32'(busy_o),    32'h0);
    rst_i = 1'b1;

    // Single request on line 2, ack three edges later, then return.
    cycle("r29a", 16'h0004, 32'h0004_0000, 1'b0, 1'b0);
    check("r29.cause_lit", mcause_o, 32'h8000_0012);
    check("r29.int_lit",   32'(int_o), 32'h1);
    cycle("r29b", 16'h0000, 32'h0000_0000, 1'b0, 1'b0);
    cycle("r29c", 16'h0000, 32'h0004_0000, 1'b0, 1'b0);
    cycle("r29d", 16'h0004, 32'h0004_0000, 1'b1, 1'b0);
    check("r29.int_after_ack", 32'(int_o), 32'h0);
    cycle("r29e", 16'h0000, 32'h0004_0000, 1'b0, 1'b1);
    check("r29.ret_lit", 32'(irq_ret_o), 32'h0004);
    cycle("r29f", 16'h0000, 32'h0004_0000, 1'b0, 1'b0);

    // Two lines at once: line 1 wins, line 2 follows after return.
    cycle("r30a", 16'h0006, 32'h0006_0000, 1'b0, 1'b0);
    check("r30.cause1_lit", mcause_o, 32'h8000_0011);
    cycle("r30b", 16'h0006, 32'h0006_0000, 1'b1, 1'b1);
    cycle("r30c", 16'h0006, 32'h0006_0000, 1'b0, 1'b1);
    check("r30.ret_lit", 32'(irq_ret_o), 32'h0002);
    cycle("r30d", 16'h0004, 32'h0006_0000, 1'b0, 1'b0);
    check("r30.ret_gone", 32'(irq_ret_o), 32'h0000);
    cycle("r30e", 16'h0004, 32'h0006_0000, 1'b0, 1'b0);
    check("r30.cause2_lit", mcause_o, 32'h8000_0012);
    cycle("r30f", 16'h0000, 32'h0006_0000, 1'b1, 1'b0);
    cycle("r30g", 16'h0000, 32'h0006_0000, 1'b0, 1'b1);
    cycle("r30h", 16'h0000, 32'h0006_0000, 1'b0, 1'b0);

    // Masked request stays silent until enabled.
    for (int i = 0; i < 10; i++) cycle("r31mask", 16'h0001, 32'h0000_0000, 1'b0, 1'b0);
    cycle("r31en", 16'h0001, 32'h0001_0000, 1'b0, 1'b0);
    check("r31.int_lit", 32'(int_o), 32'h1);
    cycle("r31ack",  16'h0000, 32'h0001_0000, 1'b1, 1'b0);
    cycle("r31mret", 16'h0000, 32'h0001_0000, 1'b0, 1'b1);
    cycle("r31idle", 16'h0000, 32'h0001_0000, 1'b0, 1'b0);

    // No preemption during service; stray mret/ack ignored.
    cycle("r32idle_mret", 16'h0000, 32'hFFFF_0000, 1'b1, 1'b1);
    cycle("r32req",  16'h0008, 32'hFFFF_0000, 1'b0, 1'b0);
    cycle("r32pmret", 16'h0008, 32'hFFFF_0000, 1'b0, 1'b1);
    check("r32.no_ret_pend", 32'(irq_ret_o), 32'h0);
    cycle("r32ack",  16'h0009, 32'hFFFF_0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("r32svc", 16'h0009, 32'hFFFF_0000, 1'b1, 1'b0);
    check("r32.no_preempt", 32'(int_o), 32'h0);
    cycle("r32mret", 16'h0001, 32'hFFFF_0000, 1'b0, 1'b1);
    check("r32.ret3_lit", 32'(irq_ret_o), 32'h0008);
    cycle("r32ret",  16'h0001, 32'hFFFF_0000, 1'b0, 1'b0);
    cycle("r32new",  16'h0001, 32'hFFFF_0000, 1'b0, 1'b0);
    check("r32.cause0_lit", mcause_o, 32'h8000_0010);

    // Reset in the middle of service: everything clears, no pulse follows.
    cycle("r33ack", 16'h0000, 32'hFFFF_0000, 1'b1, 1'b0);
    async_reset("r33");
    for (int i = 0; i < 3; i++) cycle("r33post", 16'h0000, 32'hFFFF_0000, 1'b0, 1'b1);

    // Random traffic with occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] req;
      logic [31:0] mie;
      req = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
      if ($urandom_range(0, 4) == 0) req = 16'h0;
      mie = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rnd");
      end else begin
        cycle("rnd", req, mie, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
